led_driver: RTL and testbench

//   Multi-channel LED driver that replaces the fixed free-running blink counter.

---
 rtl/led_driver.sv | 116 +++++++++++
 tb/tb_led_driver.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/led_driver.sv
// Multi-channel LED driver: each channel is off, on, blinking or PWM-dimmed,
// all sharing one prescaler, PWM frame and blink timebase.
module led_driver #(
  parameter int N_LEDS         = 3,
  parameter int PRESCALE       = 256,
  parameter int PWM_BITS       = 8,
  parameter int BLINK_DIV_BITS = 8,
  parameter int ACTIVE_LOW     = 1,
  parameter int RESET_MODE     = 2,
  localparam int AW            = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                input_clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  output logic                wr_ack,
  output logic                wr_err,
  output logic                frame_strobe,
  output logic [N_LEDS-1:0]   leds
);

  localparam int                PW        = $clog2(PRESCALE);
  localparam logic [PW-1:0]     PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [1:0]        RST_MODE  = 2'(RESET_MODE);
  localparam logic [N_LEDS-1:0] UNLIT     = {N_LEDS{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

  logic [PW-1:0]             presc;
  logic [PWM_BITS-1:0]       pwm_cnt;
  logic [BLINK_DIV_BITS-1:0] blink_cnt;
  logic                      tick;
  logic                      frame_end;
  logic                      blink_phase;
  logic [31:0]               addr_ext;
  logic                      addr_ok;
  logic [1:0]                mode        [N_LEDS];
  logic [PWM_BITS-1:0]       duty_shadow [N_LEDS];
  logic [PWM_BITS-1:0]       duty_active [N_LEDS];
  logic [N_LEDS-1:0]         lit;

  assign tick        = (presc == PRESC_MAX);
  assign frame_end   = tick && (pwm_cnt == '1);
  assign blink_phase = blink_cnt[BLINK_DIV_BITS-1];
  assign addr_ext    = 32'(wr_addr);
  assign addr_ok     = (addr_ext < 32'(N_LEDS));

  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick)
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (frame_end)
        blink_cnt <= blink_cnt + BLINK_DIV_BITS'(1);
    end
  end

  // Duty goes through a shadow register so a PWM frame never sees a half-updated duty.
  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LEDS; i++) begin
        mode[i]        <= RST_MODE;
        duty_shadow[i] <= '0;
        duty_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (frame_end)
          duty_active[i] <= duty_shadow[i];
        if (wr_en && addr_ok && (addr_ext == 32'(i))) begin
          mode[i]        <= wr_mode;
          duty_shadow[i] <= wr_duty;
        end
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      case (mode_t'(mode[i]))
        MODE_OFF:   lit[i] = 1'b0;
        MODE_ON:    lit[i] = 1'b1;
        MODE_BLINK: lit[i] = blink_phase;
        MODE_PWM:   lit[i] = (pwm_cnt < duty_active[i]);
        default:    lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack       <= 1'b0;
      wr_err       <= 1'b0;
      frame_strobe <= 1'b0;
      leds         <= UNLIT;
    end else begin
      wr_ack       <= wr_en && addr_ok;
      wr_err       <= wr_en && !addr_ok;
      frame_strobe <= frame_end;
      leds         <= lit ^ UNLIT;
    end
  end

endmodule

// File: tb/tb_led_driver.sv
// Randomized self-checking bench for led_driver; expected pins come from a
// cycle-count model of the timebase plus per-channel mode/duty bookkeeping.
module tb_led_driver;

  logic       input_clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [1:0] wr_mode;
  logic [3:0] wr_duty;
  logic       wr_ack;
  logic       wr_err;
  logic       frame_strobe;
  logic [2:0] leds;

  int checkCount = 0;
  int failCount  = 0;

  // Model: k = clock edges since reset release, plus each channel's mode and duties.
  int k;
  int mMode   [3];
  int mShadow [3];
  int mActive [3];

  led_driver #(
    .N_LEDS(3), .PRESCALE(2), .PWM_BITS(4), .BLINK_DIV_BITS(2),
    .ACTIVE_LOW(1), .RESET_MODE(2)
  ) dut (
    .input_clk(input_clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_mode(wr_mode), .wr_duty(wr_duty), .wr_ack(wr_ack), .wr_err(wr_err),
    .frame_strobe(frame_strobe), .leds(leds)
  );

  initial begin
    input_clk = 1'b0;
    forever #5 input_clk = ~input_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at k=%0d: got %0h, expected %0h", tag, k, observed, expected);
    end
  endtask

  task automatic modelReset();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      mMode[i]   = 2;
      mShadow[i] = 0;
      mActive[i] = 0;
    end
  endtask

  // Called at a negedge: drives one cycle of inputs, checks after the posedge, returns at the next negedge.
  task automatic applyStimulus(input logic wen, input logic [1:0] addr, input logic [1:0] mode, input logic [3:0] duty);
    logic [2:0] expLeds;
    logic       expAck, expErr, expStrobe;
    int         pwmStep;
    bit         frameEnd, blinkOn, lit;
    wr_en   = wen;
    wr_addr = addr;
    wr_mode = mode;
    wr_duty = duty;
    pwmStep  = (k / 2) % 16;
    frameEnd = (k % 32) == 31;
    blinkOn  = ((k / 32) % 4) >= 2;
    for (int i = 0; i < 3; i++) begin
      case (mMode[i])
        0:       lit = 1'b0;
        1:       lit = 1'b1;
        2:       lit = blinkOn;
        default: lit = pwmStep < mActive[i];
      endcase
      expLeds[i] = ~lit;
    end
    expAck    = wen && (addr < 3);
    expErr    = wen && (addr >= 3);
    expStrobe = frameEnd;
    if (frameEnd)
      for (int i = 0; i < 3; i++) mActive[i] = mShadow[i];
    if (wen && addr < 3) begin
      mMode[addr]   = int'(mode);
      mShadow[addr] = int'(duty);
    end
    k++;
    @(posedge input_clk);
    #1;
    checkOutput("leds", 32'(leds), 32'(expLeds));
    checkOutput("wr_ack", 32'(wr_ack), 32'(expAck));
    checkOutput("wr_err", 32'(wr_err), 32'(expErr));
    checkOutput("frame_strobe", 32'(frame_strobe), 32'(expStrobe));
    @(negedge input_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 2'd0, 4'd0);
  endtask

  // Reset is asserted between edges so its effect on the pins must be asynchronous.
  task automatic midFrameReset();
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0;
    #1;
    checkOutput("async_rst_leds", 32'(leds), 32'h7);
    checkOutput("async_rst_ack", 32'(wr_ack), 32'h0);
    checkOutput("async_rst_strobe", 32'(frame_strobe), 32'h0);
    @(posedge input_clk);
    #1;
    checkOutput("held_rst_leds", 32'(leds), 32'h7);
    @(negedge input_clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_mode = '0;
    wr_duty = '0;
    modelReset();
    @(negedge input_clk);
    #1;
    checkOutput("reset_leds", 32'(leds), 32'h7);
    checkOutput("reset_ack", 32'(wr_ack), 32'h0);
    checkOutput("reset_err", 32'(wr_err), 32'h0);
    checkOutput("reset_strobe", 32'(frame_strobe), 32'h0);
    @(negedge input_clk);
    rst_n = 1'b1;

    idle(200);
    applyStimulus(1'b1, 2'd1, 2'd3, 4'd4);
    idle(70);
    applyStimulus(1'b1, 2'd3, 2'd1, 4'd9);
    idle(5);
    while ((k % 32) != 31) applyStimulus(1'b0, 2'd0, 2'd0, 4'd0);
    applyStimulus(1'b1, 2'd1, 2'd3, 4'd8);
    idle(100);
    applyStimulus(1'b1, 2'd0, 2'd3, 4'd0);
    applyStimulus(1'b1, 2'd2, 2'd3, 4'd15);
    idle(70);
    applyStimulus(1'b1, 2'd0, 2'd1, 4'd0);
    idle(40);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0)
        applyStimulus(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      else
        applyStimulus(1'b0, 2'd0, 2'd0, 4'd0);
    end

    while ((k % 32) != 13) applyStimulus(1'b0, 2'd0, 2'd0, 4'd0);
    applyStimulus(1'b1, 2'd2, 2'd1, 4'd3);
    midFrameReset();
    idle(160);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
